// File: rtl/wrr_egress_fifo.sv
// Egress descriptor FIFO between the WRR arbiter (req/gnt) and MAC-TX (valid/ready).
// First-word fall-through read side, with pause, flush, occupancy and a delivered-descriptor counter.
module wrr_egress_fifo #(
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iReq,
  output logic                     oGnt,
  input  logic [DW-1:0]            iData,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [DW-1:0]            oData,
  input  logic                     iPause,
  input  logic                     iFlush,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic                     oAlmostFull,
  output logic [15:0]              oTxCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          wrEn;
  logic          rdEn;

  // Grant looks only at registered state, never at iReq, so no comb loop through the arbiter.
  assign full        = (level == LW'(DEPTH));
  assign empty       = (level == '0);
  assign oGnt        = iRst_n && !full && !iFlush;
  assign oValid      = !empty && !iPause && !iFlush;
  assign oData       = empty ? '0 : mem[rdPtr];
  assign oLevel      = level;
  assign oAlmostFull = (level >= LW'(AFULL_TH));

  assign wrEn = iReq && oGnt;
  assign rdEn = oValid && iReady;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      level  <= '0;
      oTxCnt <= '0;
    end else begin
      if (iFlush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        level <= '0;
      end else begin
        if (wrEn) wrPtr <= wrPtr + AW'(1);
        if (rdEn) rdPtr <= rdPtr + AW'(1);
        level <= level + LW'(wrEn) - LW'(rdEn);
      end
      // Counter wraps naturally at 16 bits; rdEn is already low during a flush.
      if (rdEn) oTxCnt <= oTxCnt + 16'd1;
    end
  end

  // NOTE: storage is deliberately not reset; oData is masked to 0 while empty, so contents are never observed.
  always_ff @(posedge iClk) begin
    if (wrEn) mem[wrPtr] <= iData;
  end

endmodule

// File: tb/tb_wrr_egress_fifo.sv
// Directed bench for wrr_egress_fifo: a vector table for fill/full/drain, plus
// hand-written sequences for pause, flush and asynchronous reset.
module tb_wrr_egress_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int AFULL_TH = 6;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int NVEC = 19;

  logic          iClk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          iReq = 1'b0;
  logic [DW-1:0] iData = '0;
  logic          iReady = 1'b0;
  logic          iPause = 1'b0;
  logic          iFlush = 1'b0;
  logic          oGnt;
  logic          oValid;
  logic [DW-1:0] oData;
  logic [LW-1:0] oLevel;
  logic          oAlmostFull;
  logic [15:0]   oTxCnt;

  int total = 0;
  int bad = 0;

  wrr_egress_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .oGnt(oGnt), .iData(iData),
    .oValid(oValid), .iReady(iReady), .oData(oData), .iPause(iPause),
    .iFlush(iFlush), .oLevel(oLevel), .oAlmostFull(oAlmostFull), .oTxCnt(oTxCnt)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic          req;
    logic [DW-1:0] data;
    logic          ready;
    logic          gnt;
    logic          valid;
    logic [DW-1:0] odata;
    logic [LW-1:0] level;
    logic          afull;
    logic [15:0]   txcnt;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic req, input logic [7:0] data, input logic ready,
                              input logic gnt, input logic valid, input logic [7:0] odata,
                              input int level, input logic afull, input int txcnt);
    vec_t v;
    v.req = req; v.data = data; v.ready = ready;
    v.gnt = gnt; v.valid = valid; v.odata = odata;
    v.level = LW'(level); v.afull = afull; v.txcnt = 16'(txcnt);
    return v;
  endfunction

  // Inputs change at posedge+1; outputs are checked at the following negedge.
  task automatic next_cycle();
    @(posedge iClk);
    #1;
  endtask

  logic [DW-1:0] q [$];
  int            txExp;

  task automatic drain(input string tag);
    int n;
    iReq = 1'b0; iReady = 1'b1; iPause = 1'b0; iFlush = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge iClk);
      check({tag, "_valid"}, oValid, 1'b1);
      check({tag, "_data"}, oData, q[0]);
      void'(q.pop_front());
      txExp++;
      next_cycle();
      n++;
    end
    @(negedge iClk);
    check({tag, "_empty_level"}, oLevel, 0);
    check({tag, "_empty_valid"}, oValid, 1'b0);
    iReady = 1'b0;
  endtask

  initial begin
    // Fill 00..07 without reading; a ninth request (AA) is held off until space frees.
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1'b1, 8'(i), 1'b0, 1'b1, (i > 0), 8'h00, i, (i >= AFULL_TH), 0);
    vecs[8]  = mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h00, 8, 1'b1, 0);
    vecs[9]  = mk(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'h00, 8, 1'b1, 0); // pop only
    vecs[10] = mk(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'h01, 7, 1'b1, 1); // write AA + pop 01
    vecs[11] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 7, 1'b1, 2);
    vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 6, 1'b1, 3);
    vecs[13] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 5, 1'b0, 4);
    vecs[14] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 4, 1'b0, 5);
    vecs[15] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 3, 1'b0, 6);
    vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07, 2, 1'b0, 7);
    vecs[17] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 1, 1'b0, 8);
    vecs[18] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 9);

    // Reset state, while iRst_n is still low.
    #3;
    check("rst_gnt", oGnt, 1'b0);
    check("rst_valid", oValid, 1'b0);
    check("rst_level", oLevel, 0);
    check("rst_afull", oAlmostFull, 1'b0);
    check("rst_txcnt", oTxCnt, 0);
    check("rst_data", oData, 0);
    #9 iRst_n = 1'b1;
    next_cycle();

    @(negedge iClk);
    check("idle_gnt", oGnt, 1'b1);
    check("idle_valid", oValid, 1'b0);
    check("idle_level", oLevel, 0);
    check("idle_txcnt", oTxCnt, 0);
    next_cycle();

    for (int i = 0; i < NVEC; i++) begin
      iReq = vecs[i].req; iData = vecs[i].data; iReady = vecs[i].ready;
      @(negedge iClk);
      check($sformatf("v%0d_gnt", i), oGnt, vecs[i].gnt);
      check($sformatf("v%0d_valid", i), oValid, vecs[i].valid);
      if (vecs[i].valid) check($sformatf("v%0d_data", i), oData, vecs[i].odata);
      check($sformatf("v%0d_level", i), oLevel, vecs[i].level);
      check($sformatf("v%0d_afull", i), oAlmostFull, vecs[i].afull);
      check($sformatf("v%0d_txcnt", i), oTxCnt, vecs[i].txcnt);
      next_cycle();
    end
    iReq = 1'b0; iReady = 1'b0;
    @(negedge iClk);
    check("tbl_final_txcnt", oTxCnt, 9);
    next_cycle();
    txExp = 9;

    // Continuous requests and readiness, pause toggled every 3 cycles.
    begin
      logic [DW-1:0] d;
      logic          expGnt;
      logic          expValid;
      d = 8'h80;
      for (int c = 0; c < 24; c++) begin
        iReq = 1'b1; iData = d; iReady = 1'b1; iPause = ((c / 3) % 2) == 1;
        expGnt = q.size() < DEPTH;
        expValid = (q.size() != 0) && !iPause;
        @(negedge iClk);
        check($sformatf("p%0d_level", c), oLevel, q.size());
        check($sformatf("p%0d_gnt", c), oGnt, expGnt);
        check($sformatf("p%0d_valid", c), oValid, expValid);
        if (q.size() != 0) check($sformatf("p%0d_head", c), oData, q[0]);
        check($sformatf("p%0d_txcnt", c), oTxCnt, txExp);
        if (expValid) begin
          void'(q.pop_front());
          txExp++;
        end
        if (expGnt) begin
          q.push_back(d);
          d++;
        end
        next_cycle();
      end
    end
    drain("pdrain");
    @(negedge iClk);
    check("pdrain_txcnt", oTxCnt, txExp);
    next_cycle();

    // Flush with a concurrent request: nothing written, level clears, counter kept.
    for (int i = 0; i < 5; i++) begin
      iReq = 1'b1; iData = 8'h10 + 8'(i);
      next_cycle();
    end
    iReq = 1'b1; iData = 8'h55; iFlush = 1'b1; iReady = 1'b1;
    @(negedge iClk);
    check("fl_level_before", oLevel, 5);
    check("fl_gnt", oGnt, 1'b0);
    check("fl_valid", oValid, 1'b0);
    next_cycle();
    iFlush = 1'b0; iReq = 1'b0; iReady = 1'b0;
    @(negedge iClk);
    check("fl_level_after", oLevel, 0);
    check("fl_valid_after", oValid, 1'b0);
    check("fl_txcnt", oTxCnt, txExp);
    next_cycle();
    iReq = 1'b1; iData = 8'h66;
    @(negedge iClk);
    check("fl_regnt", oGnt, 1'b1);
    next_cycle();
    iReq = 1'b0;
    @(negedge iClk);
    check("fl_head_valid", oValid, 1'b1);
    check("fl_head_data", oData, 8'h66);
    check("fl_head_level", oLevel, 1);
    next_cycle();

    // Bring level to 4, then assert reset asynchronously mid-cycle with a request pending.
    for (int i = 0; i < 3; i++) begin
      iReq = 1'b1; iData = 8'h70 + 8'(i);
      next_cycle();
    end
    iData = 8'h99;
    @(negedge iClk);
    check("ar_level_before", oLevel, 4);
    #1 iRst_n = 1'b0;
    #1;
    check("ar_gnt", oGnt, 1'b0);
    check("ar_valid", oValid, 1'b0);
    check("ar_level", oLevel, 0);
    check("ar_txcnt", oTxCnt, 0);
    check("ar_data", oData, 0);
    iReq = 1'b0;
    next_cycle();
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
    check("ar_release_gnt", oGnt, 1'b1);
    check("ar_release_level", oLevel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_egress_fifo.md
Name: wrr_egress_fifo

Overview:
- Egress descriptor buffer directly downstream of the weighted round-robin arbiter.
- Consumes the arbiter's winning request/data through a req/gnt handshake and buffers up to DEPTH descriptors.
- Presents the descriptors to the egress MAC-TX stage through a valid/ready interface.
- Provides occupancy, almost-full, pause and flush control, plus a delivered-descriptor counter for switch statistics.

Parameters:
- DW, 8, width of each descriptor word.
- DEPTH, 8, number of storage entries. Must be a power of 2 and at least 2.
- AFULL_TH, 6, oAlmostFull asserts when occupancy is at or above this value. Range 1..DEPTH.

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  asynchronous active-low reset.
- iReq  in  1  upstream request, driven by the arbiter oReq.
- oGnt  out  1  grant to upstream, drives the arbiter iGnt.
- iData  in  DW  upstream descriptor, driven by the arbiter oData.
- oValid  out  1  a descriptor is available downstream.
- iReady  in  1  downstream accepts the descriptor.
- oData  out  DW  head descriptor.
- iPause  in  1  hold egress: forces oValid to 0, storage retained.
- iFlush  in  1  synchronous discard of all stored entries.
- oLevel  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- oAlmostFull  out  1  oLevel >= AFULL_TH.
- oTxCnt  out  16  count of descriptors delivered downstream, wraps modulo 2^16.

Behaviour:
- Single clock domain (iClk). iRst_n is asynchronous assert, active-low.
- While iRst_n is low:
  - write/read pointers = 0, level = 0, oTxCnt = 0.
  - oGnt = 0, oValid = 0, oAlmostFull = 0, oLevel = 0.
  - oData = 0; memory contents are don't-care.
- Grant rule:
  - oGnt = iRst_n && !full && !iFlush.
  - oGnt is combinational from registered state only. It never depends on iReq, so there is no loop through the arbiter.
- Write: accept on the rising edge where iReq && oGnt. iData is stored at the write pointer, then wptr+1 modulo DEPTH.
- iReq without oGnt: no write. Upstream must hold iReq/iData until granted.
- Full (level == DEPTH): oGnt = 0.
  - A read in the same cycle does not enable a write. Full-plus-pop frees space on the next cycle only.
- Read side, first-word fall-through:
  - oValid = (level != 0) && !iPause && !iFlush.
  - oData = mem[rptr] whenever level != 0, else 0.
- Pop: on the rising edge where oValid && iReady, rptr+1 modulo DEPTH and oTxCnt+1.
- Latency: a descriptor written at edge N is visible on oValid/oData immediately after edge N (0 extra cycles when empty).
- Simultaneous write and pop, not full and not empty: level unchanged, both pointers advance.
- Empty (level == 0): oValid = 0; iReady is ignored.
- iPause:
  - Blocks pops only. Writes continue.
  - oData keeps showing the head entry.
  - Deassertion gives oValid = 1 in the same cycle if level != 0.
- iFlush (sampled at the rising edge), highest priority:
  - pointers and level go to 0; oTxCnt is unchanged.
  - During the flush cycle oGnt = 0 and oValid = 0, so neither a write nor a pop occurs.
  - Normal operation resumes the cycle after iFlush deasserts.
- Level arithmetic:
  - level_next = level + wr − rd, where wr and rd are each 0/1.
  - oLevel is registered. It never exceeds DEPTH and never goes below 0.
  - oAlmostFull is derived combinationally from the registered level.
- oTxCnt wraps from 16'hFFFF to 0 without saturation.
- Reset mid-transfer: all state clears immediately; the in-flight handshake is lost. Upstream re-requests after reset.

Test Plan:
- Reset then idle → oGnt = 1, oValid = 0, oLevel = 0, oTxCnt = 0.
- Write 8'h00..8'h07 with iReady = 0, DEPTH = 8:
  - oLevel reaches 8; oAlmostFull is 1 from level 6; oGnt = 0 at level 8.
  - A ninth iReq with iData = 8'hAA is not accepted.
- Full FIFO, iReady = 1 and iReq = 1 on the same cycle:
  - first edge: pop only, oLevel = 7.
  - next edge: 8'hAA written while 8'h01 pops; oLevel stays 7.
  - drain order 00..07 then AA; oTxCnt = 9.
- Continuous iReq, iReady = 1, iPause toggled every 3 cycles:
  - no pop while paused; oLevel grows by 1 per paused cycle.
  - data order and count are preserved.
- Load 5 entries, assert iFlush for 1 cycle concurrent with iReq = 1 → no write; oLevel = 0 next cycle; oTxCnt unchanged; the next write appears as the head.
- Assert iRst_n = 0 asynchronously mid-burst at level 4 → oGnt, oValid and oLevel go to 0 before the next clock edge; after release, oGnt = 1.
